// File: rtl/draw_sched.sv
// draw_sched: runs one fill-screen pass, then walks the circle command table,
// owning both engine handshakes and arbitrating the single VGA pixel port.
module draw_sched #(
    parameter int NUM_CMDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done,
    input  logic [2:0] bg_colour,
    output logic [2:0] fill_colour_cfg,
    output logic       fill_start,
    input  logic       fill_done,
    input  logic [7:0] fill_x,
    input  logic [6:0] fill_y,
    input  logic [2:0] fill_colour,
    input  logic       fill_plot,
    output logic [3:0] cmd_idx,
    input  logic [2:0] cmd_colour,
    input  logic [7:0] cmd_cx,
    input  logic [6:0] cmd_cy,
    input  logic [7:0] cmd_radius,
    input  logic       cmd_skip,
    output logic       circ_start,
    input  logic       circ_done,
    output logic [2:0] circ_colour_cfg,
    output logic [7:0] circ_cx,
    output logic [6:0] circ_cy,
    output logic [7:0] circ_radius,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic [2:0] circ_colour,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    typedef enum logic [2:0] {IDLE, FILL, LOAD, DRAW, RELEASE, NEXT, DONE} state_t;
    localparam logic [3:0] LAST = 4'(NUM_CMDS - 1);
    state_t state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cmd_idx         <= '0;
            circ_colour_cfg <= '0;
            circ_cx         <= '0;
            circ_cy         <= '0;
            circ_radius     <= '0;
        end else if (!start) begin
            // dropping start aborts from any state and wins over an engine done
            state   <= IDLE;
            cmd_idx <= '0;
        end else begin
            case (state)
                IDLE:    state <= FILL;
                FILL:    if (fill_done) begin
                    state   <= LOAD;
                    cmd_idx <= '0;
                end
                LOAD: begin
                    circ_colour_cfg <= cmd_colour;
                    circ_cx         <= cmd_cx;
                    circ_cy         <= cmd_cy;
                    circ_radius     <= cmd_radius;
                    state           <= cmd_skip ? NEXT : DRAW;
                end
                DRAW:    if (circ_done) state <= RELEASE;
                RELEASE: state <= NEXT;
                NEXT:    if (cmd_idx == LAST) state <= DONE;
                    else begin
                        cmd_idx <= cmd_idx + 4'd1;
                        state   <= LOAD;
                    end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    assign fill_start      = state == FILL;
    assign circ_start      = state == DRAW;
    assign done            = state == DONE;
    assign fill_colour_cfg = bg_colour;
    assign vga_x      = fill_start ? fill_x      : circ_start ? circ_x      : '0;
    assign vga_y      = fill_start ? fill_y      : circ_start ? circ_y      : '0;
    assign vga_colour = fill_start ? fill_colour : circ_start ? circ_colour : '0;
    assign vga_plot   = fill_start ? fill_plot   : circ_start ? circ_plot   : 1'b0;
endmodule

// File: tb/tb_draw_sched.sv
// tb_draw_sched: random tables, engine latencies and pixel traffic checked
// cycle by cycle against a per-run expected timeline built from the rules.
module tb_draw_sched;
    localparam int N = 4;
    typedef enum {P_IDLE, P_FILL, P_LOAD, P_DRAW, P_REL, P_NEXT, P_DONE} ph_t;
    typedef struct {ph_t ph; int idx;} ev_t;

    logic clk = 0, rst_n = 0, start = 0;
    logic done, fill_start, fill_done, circ_start, circ_done;
    logic [2:0] bg_colour = 0, fill_colour_cfg, fill_colour = 0, circ_colour = 0, circ_colour_cfg, vga_colour;
    logic [7:0] fill_x = 0, circ_x = 0, circ_cx, circ_radius, vga_x;
    logic [6:0] fill_y = 0, circ_y = 0, circ_cy, vga_y;
    logic fill_plot = 0, circ_plot = 0, vga_plot;
    logic [3:0] cmd_idx;
    logic [2:0] cmd_colour;
    logic [7:0] cmd_cx, cmd_radius;
    logic [6:0] cmd_cy;
    logic cmd_skip;

    logic [2:0] tab_col [16];
    logic [7:0] tab_cx [16];
    logic [6:0] tab_cy [16];
    logic [7:0] tab_r [16];
    logic tab_skip [16];
    logic scr = 0;
    logic [2:0] g_col = 0;
    logic [7:0] g_cx = 0, g_r = 0;
    logic [6:0] g_cy = 0;
    int fcnt = 0, ccnt = 0, flat = 1, clat = 1;
    int n_vec = 0, n_err = 0;
    ev_t q[$];
    ev_t idle_ev = '{P_IDLE, 0};

    always #5 clk = ~clk;

    // table reads are combinational; during DRAW the table lines carry garbage
    assign cmd_colour = scr ? g_col : tab_col[cmd_idx];
    assign cmd_cx     = scr ? g_cx  : tab_cx[cmd_idx];
    assign cmd_cy     = scr ? g_cy  : tab_cy[cmd_idx];
    assign cmd_radius = scr ? g_r   : tab_r[cmd_idx];
    assign cmd_skip   = tab_skip[cmd_idx];

    always @(posedge clk) begin
        fcnt <= fill_start ? fcnt + 1 : 0;
        ccnt <= circ_start ? ccnt + 1 : 0;
    end
    assign fill_done = fill_start && fcnt == flat - 1;
    assign circ_done = circ_start && ccnt == clat - 1;

    draw_sched #(.NUM_CMDS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .bg_colour(bg_colour), .fill_colour_cfg(fill_colour_cfg),
        .fill_start(fill_start), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .cmd_idx(cmd_idx), .cmd_colour(cmd_colour), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy),
        .cmd_radius(cmd_radius), .cmd_skip(cmd_skip),
        .circ_start(circ_start), .circ_done(circ_done),
        .circ_colour_cfg(circ_colour_cfg), .circ_cx(circ_cx), .circ_cy(circ_cy),
        .circ_radius(circ_radius),
        .circ_x(circ_x), .circ_y(circ_y), .circ_colour(circ_colour), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cycle(input ev_t e);
        bit f = e.ph == P_FILL, d = e.ph == P_DRAW;
        check("fill_start", int'(fill_start), int'(f));
        check("circ_start", int'(circ_start), int'(d));
        check("done", int'(done), int'(e.ph == P_DONE));
        check("cmd_idx", int'(cmd_idx), e.idx);
        check("fill_colour_cfg", int'(fill_colour_cfg), int'(bg_colour));
        check("vga_x", int'(vga_x), f ? int'(fill_x) : d ? int'(circ_x) : 0);
        check("vga_y", int'(vga_y), f ? int'(fill_y) : d ? int'(circ_y) : 0);
        check("vga_colour", int'(vga_colour), f ? int'(fill_colour) : d ? int'(circ_colour) : 0);
        check("vga_plot", int'(vga_plot), f ? int'(fill_plot) : d ? int'(circ_plot) : 0);
        if (d) begin
            check("circ_cx", int'(circ_cx), int'(tab_cx[e.idx]));
            check("circ_cy", int'(circ_cy), int'(tab_cy[e.idx]));
            check("circ_radius", int'(circ_radius), int'(tab_r[e.idx]));
            check("circ_colour_cfg", int'(circ_colour_cfg), int'(tab_col[e.idx]));
        end
    endtask

    task automatic step(input ev_t e);
        @(posedge clk);
        #1;
        fill_x = 8'($urandom); fill_y = 7'($urandom); fill_colour = 3'($urandom); fill_plot = 1'($urandom);
        circ_x = 8'($urandom); circ_y = 7'($urandom); circ_colour = 3'($urandom); circ_plot = 1'($urandom);
        g_cx = 8'($urandom); g_cy = 7'($urandom); g_r = 8'($urandom); g_col = 3'($urandom);
        bg_colour = 3'($urandom);
        scr = e.ph == P_DRAW;
        #1 chk_cycle(e);
    endtask

    task automatic new_table(input logic [3:0] skips);
        for (int i = 0; i < 16; i++) begin
            tab_cx[i] = 8'($urandom); tab_cy[i] = 7'($urandom);
            tab_r[i] = 8'($urandom); tab_col[i] = 3'($urandom);
            tab_skip[i] = i < N ? skips[i] : 1'b0;
        end
    endtask

    // expected timeline: fill for its latency, then per entry LOAD,
    // [DRAW x latency, RELEASE] unless skipped, NEXT; then DONE held
    task automatic build(input int hold);
        q.delete();
        repeat (flat) q.push_back('{P_FILL, 0});
        for (int i = 0; i < N; i++) begin
            q.push_back('{P_LOAD, i});
            if (!tab_skip[i]) begin
                repeat (clat) q.push_back('{P_DRAW, i});
                q.push_back('{P_REL, i});
            end
            q.push_back('{P_NEXT, i});
        end
        repeat (hold + 1) q.push_back('{P_DONE, N - 1});
    endtask

    // ab: -1 full run, -2 abort on first DRAW cycle of the last entry, else abort index
    task automatic run(input int fl, input int cl, input int ab, input int hold);
        int a = ab;
        flat = fl; clat = cl;
        build(hold);
        if (ab == -2)
            for (int k = q.size() - 1; k >= 0; k--)
                if (q[k].ph == P_DRAW && q[k].idx == N - 1) a = k;
        start = 1;
        for (int k = 0; k < q.size(); k++) begin
            step(q[k]);
            if (k == a) begin
                start = 0;
                step(idle_ev);
                return;
            end
        end
        start = 0;
        step(idle_ev);
    endtask

    task automatic rst_chk();
        check("rst fill_start", int'(fill_start), 0);
        check("rst circ_start", int'(circ_start), 0);
        check("rst done", int'(done), 0);
        check("rst cmd_idx", int'(cmd_idx), 0);
        check("rst circ_cx", int'(circ_cx), 0);
        check("rst circ_cy", int'(circ_cy), 0);
        check("rst circ_radius", int'(circ_radius), 0);
        check("rst circ_colour_cfg", int'(circ_colour_cfg), 0);
        check("rst vga_plot", int'(vga_plot), 0);
        check("rst vga_x", int'(vga_x), 0);
    endtask

    initial begin
        new_table(4'b0000);
        #1 rst_chk();
        #2 rst_n = 1;
        step(idle_ev);
        new_table(4'b0010);
        run(10, 5, -1, 3);
        new_table(4'b1111);
        run(3, 2, -1, 1);
        for (int r = 0; r < 6; r++) begin
            new_table(4'($urandom));
            run($urandom_range(1, 12), $urandom_range(1, 6), -1, $urandom_range(0, 3));
        end
        new_table(4'($urandom) & 4'b0111);
        run(4, 1, -2, 0);
        new_table(4'($urandom));
        run(5, 3, -1, 0);
        new_table(4'($urandom));
        run(6, 2, 5, 0);
        new_table(4'b0000);
        run(2, 4, -1, 0);
        flat = 12;
        start = 1;
        repeat (3) step('{P_FILL, 0});
        #2 rst_n = 0;
        #1 rst_chk();
        start = 0;
        #2 rst_n = 1;
        step(idle_ev);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
